// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t : 2-bit fetch FSM state encoding (IDLE/ISSUE/WAIT/HOLD)
//   ADDR_W_DEF    : default PC / instruction-memory address width
//   INSTR_W_DEF   : default instruction word width
//   NOP_INSTR     : instruction register contents after reset
package instr_fetch_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_wait_cnt.sv
// Memory read latency counter for the fetch sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new read; counter becomes 1
//   inc        : advance the counter by one
//   done       : counter has reached MEM_LAT (read data is valid this cycle)
module fetch_wait_cnt
  import instr_fetch_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic done
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done = (cnt == LAT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer sitting in front of the incrementable PC
// register. Issues instruction-memory reads at the current PC, captures the
// returned word into the instruction register and offers it to the decoder
// with a valid/ready handshake. Branches load the PC and cancel any read in
// flight.
//
// Optional build macro: INSTR_FETCH_PERF_CNT_EN adds fetch/stall counters.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_en                   run enable from control
//   pc_in                      current PC register value
//   pc_inc_en                  PC increment strobe
//   pc_write_en, pc_load_val   PC load strobe and value (branch target)
//   branch_en, branch_target   single-cycle branch request and destination
//   imem_addr, imem_rd_en      instruction-memory read request
//   imem_data                  instruction-memory read data
//   ir_out, ir_valid, ir_ready instruction register and decoder handshake
//   fetch_cnt, stall_cnt       (perf build only) completed handshakes and
//                              cycles with ir_valid=1, ir_ready=0
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_inc_en,
  output logic               pc_write_en,
  output logic [ADDR_W-1:0]  pc_load_val,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  input  logic               ir_ready
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  fetch_state_t state, state_n;
  logic         flush;
  logic         wait_done;
  logic         issue_go;
  logic         capture;
  logic         hold_exit;

  // A branch in the ISSUE cycle takes the PC write port, so the read and the
  // increment are held back until the next cycle.
  assign issue_go  = (state == ISSUE) && !branch_en;
  // A branch arriving in the data-return cycle wins over the capture.
  assign capture   = (state == WAIT) && wait_done && !flush && !branch_en;
  // HOLD is left either by the decoder taking the word or by a branch.
  assign hold_exit = (state == HOLD) && (ir_ready || branch_en);

  fetch_wait_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (issue_go),
    .inc   ((state == WAIT) && !wait_done),
    .done  (wait_done)
  );

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (fetch_en && !branch_en) begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!branch_en) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (wait_done) begin
          if (flush || branch_en) begin
            state_n = fetch_en ? ISSUE : IDLE;
          end else begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_exit) begin
          state_n = fetch_en ? ISSUE : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- output logic ----
  // The branch strobe is qualified by rst_n so every output reads zero while
  // reset is held, even if a branch request is present.
  always_comb begin
    imem_rd_en  = issue_go;
    pc_inc_en   = issue_go;
    imem_addr   = issue_go ? pc_in : '0;
    pc_write_en = branch_en && rst_n;
    pc_load_val = (branch_en && rst_n) ? branch_target : '0;
  end

  // ---- instruction register and flush flag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_out   <= INSTR_W'(NOP_INSTR);
      ir_valid <= 1'b0;
      flush    <= 1'b0;
    end else begin
      if (capture) begin
        ir_out   <= imem_data;
        ir_valid <= 1'b1;
      end else if (hold_exit) begin
        ir_valid <= 1'b0;
      end
      // The flag marks the outstanding read as stale; it is consumed when
      // that read's data arrives.
      if (state == WAIT) begin
        if (wait_done) begin
          flush <= 1'b0;
        end else if (branch_en) begin
          flush <= 1'b1;
        end
      end
    end
  end

`ifdef INSTR_FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (ir_valid && ir_ready) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (ir_valid && !ir_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one instance with MEM_LAT=1 driven from a
// per-cycle vector table, and one with MEM_LAT=3 for the flush, latency and
// asynchronous-reset sequences. Both share fetch_en/branch/ir_ready inputs;
// each has its own PC register model and instruction memory model.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst3_n;
  logic        fetch_en, branch_en, ir_ready;
  logic [15:0] branch_target;

  logic [15:0] pc_in, pc_load_val, imem_addr, imem_data, ir_out;
  logic        pc_inc_en, pc_write_en, imem_rd_en, ir_valid;
  logic [15:0] pc_in3, pc_load_val3, imem_addr3, imem_data3, ir_out3;
  logic        pc_inc_en3, pc_write_en3, imem_rd_en3, ir_valid3;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, fetch_cnt3, stall_cnt3;
`endif

  instr_fetch #(.ADDR_W(16), .INSTR_W(16), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_in(pc_in),
    .pc_inc_en(pc_inc_en), .pc_write_en(pc_write_en), .pc_load_val(pc_load_val),
    .branch_en(branch_en), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
    .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready)
`ifdef INSTR_FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  instr_fetch #(.ADDR_W(16), .INSTR_W(16), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .fetch_en(fetch_en), .pc_in(pc_in3),
    .pc_inc_en(pc_inc_en3), .pc_write_en(pc_write_en3), .pc_load_val(pc_load_val3),
    .branch_en(branch_en), .branch_target(branch_target),
    .imem_addr(imem_addr3), .imem_rd_en(imem_rd_en3), .imem_data(imem_data3),
    .ir_out(ir_out3), .ir_valid(ir_valid3), .ir_ready(ir_ready)
`ifdef INSTR_FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt3), .stall_cnt(stall_cnt3)
`endif
  );

  // Memory contents: word at address a is a ^ 16'hA5D3.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hA5D3;
  endfunction

  // PC register models (increment has priority over write).
  logic        pc_set = 1'b0, pc3_set = 1'b0;
  logic [15:0] pc_set_val = '0, pc3_set_val = '0;
  logic [15:0] pc = '0, pc3 = '0;
  assign pc_in  = pc;
  assign pc_in3 = pc3;

  always @(posedge clk) begin
    if (pc_set)           pc <= pc_set_val;
    else if (pc_inc_en)   pc <= pc + 16'd1;
    else if (pc_write_en) pc <= pc_load_val;
    if (pc3_set)           pc3 <= pc3_set_val;
    else if (pc_inc_en3)   pc3 <= pc3 + 16'd1;
    else if (pc_write_en3) pc3 <= pc3_load_val_f();
  end

  function automatic logic [15:0] pc3_load_val_f();
    return pc_load_val3;
  endfunction

  // Instruction memories: 1-cycle and 3-cycle read latency.
  logic [15:0] mem_q = '0, m1 = '0, m2 = '0, m3 = '0;
  assign imem_data  = mem_q;
  assign imem_data3 = m3;
  always @(posedge clk) begin
    if (imem_rd_en)  mem_q <= memf(imem_addr);
    if (imem_rd_en3) m1 <= memf(imem_addr3);
    m2 <= m1;
    m3 <= m2;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {rd_en, inc_en, write_en, imem_addr, pc_load_val, ir_valid, ir_out}
  function automatic logic [63:0] mk(input logic rd, input logic inc, input logic wr,
                                     input logic [15:0] addr, input logic [15:0] ld,
                                     input logic vld, input logic [15:0] ir);
    return {12'd0, rd, inc, wr, addr, ld, vld, ir};
  endfunction

  function automatic logic [63:0] got1();
    return mk(imem_rd_en, pc_inc_en, pc_write_en, imem_addr, pc_load_val, ir_valid, ir_out);
  endfunction

  function automatic logic [63:0] got3();
    return mk(imem_rd_en3, pc_inc_en3, pc_write_en3, imem_addr3, pc_load_val3, ir_valid3, ir_out3);
  endfunction

  typedef struct {
    string       name;
    logic        fe, br, rdy;
    logic [15:0] tgt;
    logic [63:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic fe, input logic br, input logic [15:0] tgt,
                     input logic rdy, input logic rd, input logic inc, input logic wr,
                     input logic [15:0] addr, input logic [15:0] ld, input logic vld,
                     input logic [15:0] ir);
    vec_t v;
    v.name = nm; v.fe = fe; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.exp = mk(rd, inc, wr, addr, ld, vld, ir);
    vq.push_back(v);
  endtask

  // Apply one cycle of inputs on the falling edge; outputs are sampled 1 later.
  task automatic drive(input logic fe, input logic br, input logic [15:0] tgt, input logic rdy);
    @(negedge clk);
    fetch_en = fe; branch_en = br; branch_target = tgt; ir_ready = rdy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    fetch_en = 1'b0; branch_en = 1'b0; branch_target = '0; ir_ready = 1'b0;

    @(negedge clk);
    pc_set = 1'b1; pc_set_val = 16'h0010;
    pc3_set = 1'b1; pc3_set_val = 16'h0080;
    @(negedge clk);
    pc_set = 1'b0; pc3_set = 1'b0;
    #1;
    chk("reset_dut1", got1(), 64'd0);
    chk("reset_dut3", got3(), 64'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
    chk("reset_perf", {fetch_cnt, stall_cnt}, 64'd0);
`endif

    //   name            fe br tgt       rdy rd inc wr addr      ld        vld ir
    add("t1_idle",       1, 0, 16'h0000, 1,  0, 0,  0, 16'h0000, 16'h0000, 0, 16'h0000);
    add("t1_issue",      1, 0, 16'h0000, 1,  1, 1,  0, 16'h0010, 16'h0000, 0, 16'h0000);
    add("t1_wait",       1, 0, 16'h0000, 1,  0, 0,  0, 16'h0000, 16'h0000, 0, 16'h0000);
    add("t1_hold",       1, 0, 16'h0000, 1,  0, 0,  0, 16'h0000, 16'h0000, 1, 16'hA5C3);
    add("t1_issue2",     1, 0, 16'h0000, 1,  1, 1,  0, 16'h0011, 16'h0000, 0, 16'hA5C3);
    add("t2_wait",       1, 0, 16'h0000, 0,  0, 0,  0, 16'h0000, 16'h0000, 0, 16'hA5C3);
    for (int i = 0; i < 5; i++)
      add("t2_stall",    1, 0, 16'h0000, 0,  0, 0,  0, 16'h0000, 16'h0000, 1, 16'hA5C2);
    add("t2_release",    0, 0, 16'h0000, 1,  0, 0,  0, 16'h0000, 16'h0000, 1, 16'hA5C2);
    add("br_idle",       0, 1, 16'h0040, 0,  0, 0,  1, 16'h0000, 16'h0040, 0, 16'hA5C2);
    add("t3_idle",       1, 0, 16'h0000, 0,  0, 0,  0, 16'h0000, 16'h0000, 0, 16'hA5C2);
    add("t3_issue",      1, 0, 16'h0000, 0,  1, 1,  0, 16'h0040, 16'h0000, 0, 16'hA5C2);
    add("t3_br_wait",    1, 1, 16'h0200, 0,  0, 0,  1, 16'h0000, 16'h0200, 0, 16'hA5C2);
    add("t3_issue_tgt",  1, 0, 16'h0000, 1,  1, 1,  0, 16'h0200, 16'h0000, 0, 16'hA5C2);
    add("t4_wait",       1, 0, 16'h0000, 1,  0, 0,  0, 16'h0000, 16'h0000, 0, 16'hA5C2);
    add("t4_hold",       1, 0, 16'h0000, 1,  0, 0,  0, 16'h0000, 16'h0000, 1, 16'hA7D3);
    add("t4_br_issue",   1, 1, 16'h1234, 1,  0, 0,  1, 16'h0000, 16'h1234, 0, 16'hA7D3);
    add("t4_issue_tgt",  1, 0, 16'h0000, 1,  1, 1,  0, 16'h1234, 16'h0000, 0, 16'hA7D3);
    add("fe_off_wait",   0, 0, 16'h0000, 0,  0, 0,  0, 16'h0000, 16'h0000, 0, 16'hA7D3);
    add("fe_off_hold",   0, 0, 16'h0000, 0,  0, 0,  0, 16'h0000, 16'h0000, 1, 16'hB7E7);
    add("br_hold",       0, 1, 16'h0300, 0,  0, 0,  1, 16'h0000, 16'h0300, 1, 16'hB7E7);
    add("idle_end",      0, 0, 16'h0000, 0,  0, 0,  0, 16'h0000, 16'h0000, 0, 16'hB7E7);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].fe, vq[i].br, vq[i].tgt, vq[i].rdy);
      chk(vq[i].name, got1(), vq[i].exp);
      chk({vq[i].name, "_excl"}, {63'd0, pc_inc_en && pc_write_en}, 64'd0);
    end

`ifdef INSTR_FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", {32'd0, fetch_cnt}, 64'd3);
    chk("perf_stall_cnt", {32'd0, stall_cnt}, 64'd7);
`endif

    // MEM_LAT=3: branch during WAIT flushes the outstanding read.
    @(negedge clk);
    rst3_n = 1'b1;
    drive(1, 0, 16'h0000, 1); chk("r3_idle",      got3(), mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000));
    drive(1, 0, 16'h0000, 1); chk("r3_issue",     got3(), mk(1, 1, 0, 16'h0080, 16'h0000, 0, 16'h0000));
    drive(1, 1, 16'h0090, 1); chk("r3_br_wait",   got3(), mk(0, 0, 1, 16'h0000, 16'h0090, 0, 16'h0000));
    drive(1, 0, 16'h0000, 1); chk("r3_wait2",     got3(), mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000));
    drive(1, 0, 16'h0000, 1); chk("r3_drop",      got3(), mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000));
    drive(1, 0, 16'h0000, 1); chk("r3_issue_tgt", got3(), mk(1, 1, 0, 16'h0090, 16'h0000, 0, 16'h0000));
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 16'h0000, 1);
      chk("r3_latency", got3(), mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000));
    end
    drive(1, 0, 16'h0000, 1); chk("r3_hold",      got3(), mk(0, 0, 0, 16'h0000, 16'h0000, 1, 16'hA543));
    drive(1, 0, 16'h0000, 1); chk("r3_issue2",    got3(), mk(1, 1, 0, 16'h0091, 16'h0000, 0, 16'hA543));
    drive(1, 0, 16'h0000, 1); chk("r3_wait_pre",  got3(), mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'hA543));

    // Asynchronous reset in the middle of a WAIT cycle.
    #2;
    rst3_n = 1'b0;
    #1;
    chk("r3_async_rst", got3(), 64'd0);
    drive(0, 0, 16'h0000, 1);
    drive(0, 0, 16'h0000, 1);
    rst3_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 16'h0000, 1);
      chk("r3_late_data", got3(), 64'd0);
    end
    drive(1, 0, 16'h0000, 1); chk("r3_restart_idle", got3(), 64'd0);
    drive(1, 0, 16'h0000, 1); chk("r3_restart",  got3(), mk(1, 1, 0, 16'h0092, 16'h0000, 0, 16'h0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch sequencer directly upstream of the 16-bit incrementable PC register.
- Reads the current PC value, issues instruction-memory reads, and latches the returned word into an instruction register.
- Hands the instruction to the decoder with a valid/ready handshake.
- Drives the PC register's increment and write enables, and its load data for branches.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- INSTR_W, 16, instruction word width.
- MEM_LAT, 1, instruction-memory read latency in cycles (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  core run enable from control.
- pc_in  in  ADDR_W  current PC register value.
- pc_inc_en  out  1  PC increment strobe.
- pc_write_en  out  1  PC load strobe.
- pc_load_val  out  ADDR_W  PC load value, the branch target.
- branch_en  in  1  branch request, single-cycle pulse.
- branch_target  in  ADDR_W  branch destination.
- imem_addr  out  ADDR_W  instruction-memory address.
- imem_rd_en  out  1  instruction-memory read strobe.
- imem_data  in  INSTR_W  instruction-memory read data.
- ir_out  out  INSTR_W  latched instruction.
- ir_valid  out  1  ir_out holds a valid instruction.
- ir_ready  in  1  decoder accepts ir_out.

Behaviour:
- Reset:
  - Async on rst_n=0; state IDLE.
  - All outputs 0: ir_out=0, ir_valid=0, imem_rd_en=0, pc_inc_en=0, pc_write_en=0, imem_addr=0, pc_load_val=0.
  - Wait counter and flush flag cleared.
  - Any read in flight at reset is abandoned; its data is never captured.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: fetch_en=1 -> ISSUE.
- ISSUE, single cycle:
  - imem_addr=pc_in, imem_rd_en=1, pc_inc_en=1 (PC becomes pc_in+1 at the next edge).
  - Counter loads 1; -> WAIT.
- WAIT:
  - Counter increments each cycle.
  - In the cycle where counter==MEM_LAT: if flush=0, ir_out<=imem_data, ir_valid<=1, -> HOLD.
  - If flush=1: drop the data, clear flush, -> ISSUE when fetch_en=1, else IDLE.
- HOLD:
  - ir_valid=1 and ir_out stable until ir_valid&&ir_ready.
  - On handshake: ir_valid<=0; -> ISSUE if fetch_en=1, else IDLE.
- Latency and throughput:
  - Issue to ir_valid is MEM_LAT+1 edges.
  - Peak rate is one instruction per MEM_LAT+2 cycles when ir_ready is held high.
- Strobe exclusivity:
  - The PC register gives increment priority over write, so pc_inc_en and pc_write_en are never asserted in the same cycle.
  - A branch wins over a fetch.
- Branch, accepted in any state (branch_en=1):
  - Drive pc_write_en=1 and pc_load_val=branch_target for exactly that cycle.
  - IDLE: stay IDLE.
  - ISSUE: suppress imem_rd_en and pc_inc_en; remain in ISSUE and issue next cycle from the new PC.
  - WAIT: set flush.
  - HOLD: ir_valid<=0; -> ISSUE if fetch_en=1, else IDLE. A handshake in the same cycle still completes; the instruction counts as consumed.
- Branch pulses on consecutive cycles: the last target wins; each pulse produces its own write strobe.
- fetch_en deasserted mid-operation:
  - The current read completes and is held in HOLD until consumed.
  - No new ISSUE is started.
- PC wrap: 16'hFFFF+1 -> 16'h0000, performed by the PC register; no special handling here.

Optional Feature:
- Macro: INSTR_FETCH_PERF_CNT_EN.
- When defined, add two output ports:
  - fetch_cnt[31:0]: increments on every completed handshake.
  - stall_cnt[31:0]: increments every cycle with ir_valid=1 and ir_ready=0.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - fetch FSM state enum (IDLE/ISSUE/WAIT/HOLD, 2-bit encoding);
  - ADDR_W/INSTR_W defaults;
  - NOP instruction constant 16'h0000.
- Sub-module: fetch_wait_cnt, the MEM_LAT latency counter with load/increment and a done flag.
- FSM and output logic stay in instr_fetch.

Test Plan:
1. Reset release, fetch_en=1, pc_in=0x0010, MEM_LAT=1, imem_data=0xA5C3, ir_ready=1:
   -> imem_rd_en and pc_inc_en high for 1 cycle, imem_addr=0x0010; ir_out=0xA5C3 with ir_valid 2 edges after issue; handshake; next issue from 0x0011.
2. ir_ready held 0 for 5 cycles in HOLD:
   -> ir_valid stays 1, ir_out constant, no imem_rd_en; ir_ready=1 ends HOLD in the same cycle.
3. branch_en with target 0x0200 in the WAIT cycle of a fetch from 0x0040:
   -> pc_write_en=1, pc_load_val=0x0200; returning data dropped (ir_valid stays 0); next issue at 0x0200; pc_inc_en never coincides with pc_write_en.
4. branch_en in an ISSUE cycle, target 0x1234:
   -> no imem_rd_en or pc_inc_en that cycle; issue with imem_addr=0x1234 the next cycle.
5. rst_n pulsed low during WAIT with MEM_LAT=3:
   -> all outputs 0 immediately (async); late memory data ignored; clean restart from IDLE.
6. Run with INSTR_FETCH_PERF_CNT_EN defined, 4 fetches with 3 total stall cycles:
   -> fetch_cnt=4, stall_cnt=3.
